// File: rtl/ct_lsu_pfu_pfb_l1_pfgen.sv
// ct_lsu_pfu_pfb_l1_pfgen
//   Per-entry L1 prefetch address generator for the PFU prefetch buffer.
//   While the entry top state machine sits in JUDGE, this block walks
//   pf_va = inst_new_va + n*stride, obtains a PPN for each new 4K page and
//   raises one-cycle MMU / BIU pe-req set pulses.  It keeps the number of
//   lines issued ahead of demand at or below the programmed distance.
//
//   Build option: CT_LSU_PFU_L1_PPN_REUSE_EN
//     defined     - a next pf_va that stays in the latched page reuses the
//                   latched PPN and goes straight to the BIU request.
//     not defined - every grant drops the latched PPN and re-translates.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | not walking; pf_va reloaded from inst_new_va on JUDGE
//   REQ_MMU   | one-cycle MMU set pulse for pf_va
//   WAIT_PPN  | waiting for the MMU ack (error ends the walk in STOP)
//   REQ_BIU   | one-cycle BIU set pulse for pf_pa
//   WAIT_BIU  | waiting for an l1 grant; grant advances pf_va, cnt+1
//   FULL      | distance reached; waits for demand to consume a line
//   STOP      | translation fault; no requests until abort/reinit
module ct_lsu_pfu_pfb_l1_pfgen #(
    parameter int PA_WIDTH  = 40,
    parameter int CNT_WIDTH = 5
) (
    input  logic                    entry_clk,
    input  logic                    cpurst_b,
    input  logic                    entry_tsm_is_judge,
    input  logic                    entry_pop_vld,
    input  logic                    entry_reinit_vld,
    input  logic                    entry_pf_inst_vld,
    input  logic [PA_WIDTH-1:0]     entry_inst_new_va,
    input  logic [10:0]             entry_stride,
    input  logic                    entry_stride_neg,
    input  logic [1:0]              cp0_lsu_pfu_l1_dist,
    input  logic                    entry_l1_mmu_ack_vld,
    input  logic                    entry_l1_mmu_ack_err,
    input  logic [PA_WIDTH-13:0]    entry_l1_mmu_ack_ppn,
    input  logic                    entry_biu_pe_req_grnt,
    input  logic [1:0]              entry_biu_pe_req_src,
    output logic                    entry_l1_mmu_pe_req_set,
    output logic                    entry_l1_biu_pe_req_set,
    output logic [PA_WIDTH-1:0]     entry_l1_pf_va,
    output logic [PA_WIDTH-1:0]     entry_l1_pf_pa,
    output logic [CNT_WIDTH-1:0]    entry_l1_cnt
);

    localparam int PPN_WIDTH = PA_WIDTH - 12;

`ifdef CT_LSU_PFU_L1_PPN_REUSE_EN
    localparam bit PPN_REUSE = 1'b1;
`else
    localparam bit PPN_REUSE = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ_MMU  = 3'd1,
        ST_WAIT_PPN = 3'd2,
        ST_REQ_BIU  = 3'd3,
        ST_WAIT_BIU = 3'd4,
        ST_FULL     = 3'd5,
        ST_STOP     = 3'd6
    } state_t;

    state_t                 state_q,   state_d;
    logic [PA_WIDTH-1:0]    pf_va_q,   pf_va_d;
    logic [PPN_WIDTH-1:0]   ppn_q,     ppn_d;
    logic [PPN_WIDTH-1:0]   ppn_tag_q, ppn_tag_d;
    logic                   ppn_vld_q, ppn_vld_d;
    logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;

    logic [PA_WIDTH-1:0]    stride_ext;
    logic [PA_WIDTH-1:0]    pf_va_inc;
    logic [CNT_WIDTH-1:0]   dist_lines;
    logic                   abort;
    logic                   grant_l1;
    logic                   src_unused;

    // Only the l1 source bit matters here; the l2 bit belongs to another generator.
    assign src_unused = entry_biu_pe_req_src[1];

    // Sign-extended stride, next address candidate and decoded distance.
    always_comb begin
        stride_ext = {{(PA_WIDTH-11){entry_stride_neg}}, entry_stride};
        pf_va_inc  = pf_va_q + stride_ext;
        case (cp0_lsu_pfu_l1_dist)
            2'd0:    dist_lines = CNT_WIDTH'(2);
            2'd1:    dist_lines = CNT_WIDTH'(4);
            2'd2:    dist_lines = CNT_WIDTH'(8);
            default: dist_lines = CNT_WIDTH'(16);
        endcase
        // pop, reinit and loss of JUDGE all return to IDLE with the same
        // clean-up, so their relative priority does not change the result.
        abort    = entry_pop_vld | entry_reinit_vld | ~entry_tsm_is_judge;
        grant_l1 = entry_biu_pe_req_grnt & entry_biu_pe_req_src[0];
    end

    // Next-state, address walk, PPN latch and outstanding-line counter.
    always_comb begin
        state_d   = state_q;
        pf_va_d   = pf_va_q;
        ppn_d     = ppn_q;
        ppn_tag_d = ppn_tag_q;
        ppn_vld_d = ppn_vld_q;
        cnt_d     = cnt_q;

        // Demand consumption lowers the count anywhere outside IDLE, floor 0.
        if (state_q != ST_IDLE && entry_pf_inst_vld && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end

        if (abort) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            ppn_vld_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (entry_tsm_is_judge) begin
                        pf_va_d = entry_inst_new_va;
                        cnt_d   = '0;
                        state_d = ST_REQ_MMU;
                    end
                end
                ST_REQ_MMU: begin
                    state_d = ST_WAIT_PPN;
                end
                ST_WAIT_PPN: begin
                    if (entry_l1_mmu_ack_vld) begin
                        if (entry_l1_mmu_ack_err) begin
                            state_d = ST_STOP;
                        end else begin
                            ppn_d     = entry_l1_mmu_ack_ppn;
                            ppn_tag_d = pf_va_q[PA_WIDTH-1:12];
                            ppn_vld_d = 1'b1;
                            state_d   = ST_REQ_BIU;
                        end
                    end
                end
                ST_REQ_BIU: begin
                    state_d = ST_WAIT_BIU;
                end
                ST_WAIT_BIU: begin
                    if (grant_l1) begin
                        pf_va_d = pf_va_inc;
                        // A demand hit in the grant cycle cancels the increment.
                        if (entry_pf_inst_vld) begin
                            cnt_d = cnt_q;
                        end else begin
                            cnt_d = cnt_q + CNT_WIDTH'(1);
                        end
                        ppn_vld_d = PPN_REUSE ? ppn_vld_q : 1'b0;
                        // >= rather than == so a shrunk distance still parks in FULL.
                        if (cnt_d >= dist_lines) begin
                            state_d = ST_FULL;
                        end else if (ppn_vld_d &&
                                     pf_va_inc[PA_WIDTH-1:12] == ppn_tag_q) begin
                            state_d = ST_REQ_BIU;
                        end else begin
                            state_d = ST_REQ_MMU;
                        end
                    end
                end
                ST_FULL: begin
                    // Leave only when a consumed line brings us under the distance.
                    if (entry_pf_inst_vld && cnt_d < dist_lines) begin
                        if (ppn_vld_q && pf_va_q[PA_WIDTH-1:12] == ppn_tag_q) begin
                            state_d = ST_REQ_BIU;
                        end else begin
                            state_d = ST_REQ_MMU;
                        end
                    end
                end
                ST_STOP: begin
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q   <= ST_IDLE;
            pf_va_q   <= '0;
            ppn_q     <= '0;
            ppn_tag_q <= '0;
            ppn_vld_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pf_va_q   <= pf_va_d;
            ppn_q     <= ppn_d;
            ppn_tag_q <= ppn_tag_d;
            ppn_vld_q <= ppn_vld_d;
            cnt_q     <= cnt_d;
        end
    end

    // Set pulses are plain decodes of the registered request states.
    always_comb begin
        entry_l1_mmu_pe_req_set = (state_q == ST_REQ_MMU);
        entry_l1_biu_pe_req_set = (state_q == ST_REQ_BIU);
        entry_l1_pf_va          = pf_va_q;
        entry_l1_pf_pa          = {ppn_q, pf_va_q[11:0]};
        entry_l1_cnt            = cnt_q;
    end

endmodule

// File: tb/tb_ct_lsu_pfu_pfb_l1_pfgen.sv
// Testbench for ct_lsu_pfu_pfb_l1_pfgen: directed scenarios followed by
// randomized walks, checked against a transaction-level model of the
// prefetch walk (address arithmetic, page test, line budget).
module tb_ct_lsu_pfu_pfb_l1_pfgen;

    logic        entry_clk = 1'b0;
    logic        cpurst_b;
    logic        entry_tsm_is_judge;
    logic        entry_pop_vld;
    logic        entry_reinit_vld;
    logic        entry_pf_inst_vld;
    logic [39:0] entry_inst_new_va;
    logic [10:0] entry_stride;
    logic        entry_stride_neg;
    logic [1:0]  cp0_lsu_pfu_l1_dist;
    logic        entry_l1_mmu_ack_vld;
    logic        entry_l1_mmu_ack_err;
    logic [27:0] entry_l1_mmu_ack_ppn;
    logic        entry_biu_pe_req_grnt;
    logic [1:0]  entry_biu_pe_req_src;
    logic        entry_l1_mmu_pe_req_set;
    logic        entry_l1_biu_pe_req_set;
    logic [39:0] entry_l1_pf_va;
    logic [39:0] entry_l1_pf_pa;
    logic [4:0]  entry_l1_cnt;

    ct_lsu_pfu_pfb_l1_pfgen dut (
        .entry_clk               (entry_clk),
        .cpurst_b                (cpurst_b),
        .entry_tsm_is_judge      (entry_tsm_is_judge),
        .entry_pop_vld           (entry_pop_vld),
        .entry_reinit_vld        (entry_reinit_vld),
        .entry_pf_inst_vld       (entry_pf_inst_vld),
        .entry_inst_new_va       (entry_inst_new_va),
        .entry_stride            (entry_stride),
        .entry_stride_neg        (entry_stride_neg),
        .cp0_lsu_pfu_l1_dist     (cp0_lsu_pfu_l1_dist),
        .entry_l1_mmu_ack_vld    (entry_l1_mmu_ack_vld),
        .entry_l1_mmu_ack_err    (entry_l1_mmu_ack_err),
        .entry_l1_mmu_ack_ppn    (entry_l1_mmu_ack_ppn),
        .entry_biu_pe_req_grnt   (entry_biu_pe_req_grnt),
        .entry_biu_pe_req_src    (entry_biu_pe_req_src),
        .entry_l1_mmu_pe_req_set (entry_l1_mmu_pe_req_set),
        .entry_l1_biu_pe_req_set (entry_l1_biu_pe_req_set),
        .entry_l1_pf_va          (entry_l1_pf_va),
        .entry_l1_pf_pa          (entry_l1_pf_pa),
        .entry_l1_cnt            (entry_l1_cnt)
    );

    always #5 entry_clk = ~entry_clk;

`ifdef CT_LSU_PFU_L1_PPN_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Model of the walk: 0 = no request expected, 1 = MMU, 2 = BIU.
    logic [39:0] m_va;
    logic [27:0] m_ppn;
    logic [27:0] m_tag;
    bit          m_pv;
    longint      m_step;
    int          m_cnt;
    int          m_lines;
    int          m_exp;
    bit          rnd_mode;

    function automatic int lines_of(logic [1:0] d);
        return 2 << d;
    endfunction

    function automatic longint step_of(logic [10:0] s, logic n);
        return n ? (longint'(s) - 2048) : longint'(s);
    endfunction

    function automatic int page_req();
        return (m_pv && m_va[39:12] == m_tag) ? 2 : 1;
    endfunction

    task automatic chk(string tag, logic [39:0] obs, logic [39:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge entry_clk);
        @(negedge entry_clk);
    endtask

    task automatic check_state(string tag, int exp);
        chk({tag, "_mmu_set"}, 40'(entry_l1_mmu_pe_req_set), 40'(exp == 1));
        chk({tag, "_biu_set"}, 40'(entry_l1_biu_pe_req_set), 40'(exp == 2));
        chk({tag, "_pf_va"}, entry_l1_pf_va, m_va);
        chk({tag, "_cnt"}, 40'(entry_l1_cnt), 40'(m_cnt));
        if (exp == 2) chk({tag, "_pf_pa"}, entry_l1_pf_pa, {m_ppn, m_va[11:0]});
    endtask

    task automatic idle_cycles(string tag, int n, bit allow_inst);
        bit inst;
        for (int i = 0; i < n; i++) begin
            inst = allow_inst && ($urandom_range(0, 3) == 0);
            entry_pf_inst_vld = inst;
            tick();
            entry_pf_inst_vld = 1'b0;
            if (inst && m_cnt > 0) m_cnt--;
            check_state(tag, 0);
        end
    endtask

    task automatic start(logic [39:0] va, logic [10:0] s, logic n, logic [1:0] d);
        entry_tsm_is_judge = 1'b0;
        tick();
        chk("abort_mmu_set", 40'(entry_l1_mmu_pe_req_set), 40'd0);
        chk("abort_cnt", 40'(entry_l1_cnt), 40'd0);
        entry_inst_new_va   = va;
        entry_stride        = s;
        entry_stride_neg    = n;
        cp0_lsu_pfu_l1_dist = d;
        entry_tsm_is_judge  = 1'b1;
        tick();
        m_va    = va;
        m_step  = step_of(s, n);
        m_lines = lines_of(d);
        m_cnt   = 0;
        m_pv    = 1'b0;
        m_exp   = 1;
        check_state("start", 1);
    endtask

    task automatic ack(logic [27:0] ppn);
        // An ack while still in the request cycle must be ignored.
        if (rnd_mode && $urandom_range(0, 2) == 0) begin
            entry_l1_mmu_ack_vld = 1'b1;
            entry_l1_mmu_ack_ppn = 28'($urandom);
        end
        tick();
        entry_l1_mmu_ack_vld = 1'b0;
        check_state("ack_wait", 0);
        if (rnd_mode) idle_cycles("ack_idle", $urandom_range(0, 2), 1'b1);
        entry_l1_mmu_ack_vld = 1'b1;
        entry_l1_mmu_ack_ppn = ppn;
        tick();
        entry_l1_mmu_ack_vld = 1'b0;
        entry_l1_mmu_ack_ppn = 28'($urandom);
        m_ppn = ppn;
        m_tag = m_va[39:12];
        m_pv  = 1'b1;
        m_exp = 2;
        check_state("ack", 2);
    endtask

    task automatic grant(bit with_inst, logic [1:0] new_dist);
        tick();
        check_state("grant_wait", 0);
        if (rnd_mode) idle_cycles("grant_idle", $urandom_range(0, 2), 1'b1);
        if (rnd_mode && $urandom_range(0, 3) == 0) begin
            // l2-only grant and a stray MMU ack: neither may move the walk.
            entry_biu_pe_req_grnt = 1'b1;
            entry_biu_pe_req_src  = 2'b10;
            entry_l1_mmu_ack_vld  = 1'b1;
            tick();
            entry_biu_pe_req_grnt = 1'b0;
            entry_biu_pe_req_src  = 2'b00;
            entry_l1_mmu_ack_vld  = 1'b0;
            check_state("l2_grant", 0);
        end
        cp0_lsu_pfu_l1_dist   = new_dist;
        m_lines               = lines_of(new_dist);
        entry_biu_pe_req_grnt = 1'b1;
        entry_biu_pe_req_src  = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01;
        entry_pf_inst_vld     = with_inst;
        tick();
        entry_biu_pe_req_grnt = 1'b0;
        entry_biu_pe_req_src  = 2'b00;
        entry_pf_inst_vld     = 1'b0;
        m_va = 40'(longint'(m_va) + m_step);
        if (!with_inst) m_cnt++;
        if (!REUSE) m_pv = 1'b0;
        m_exp = (m_cnt >= m_lines) ? 0 : page_req();
        check_state("grant", m_exp);
    endtask

    task automatic consume();
        if (rnd_mode) idle_cycles("full_idle", $urandom_range(0, 2), 1'b0);
        entry_pf_inst_vld = 1'b1;
        tick();
        entry_pf_inst_vld = 1'b0;
        m_cnt--;
        m_exp = (m_cnt < m_lines) ? page_req() : 0;
        check_state("consume", m_exp);
    endtask

    task automatic serve();
        bit          inst;
        logic [1:0]  d;
        inst = rnd_mode && ($urandom_range(0, 3) == 0);
        d    = cp0_lsu_pfu_l1_dist;
        if (rnd_mode && $urandom_range(0, 7) == 0) d = 2'($urandom_range(0, 3));
        case (m_exp)
            1:       ack(28'($urandom));
            2:       grant(inst, d);
            default: consume();
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        cpurst_b              = 1'b0;
        entry_tsm_is_judge    = 1'b0;
        entry_pop_vld         = 1'b0;
        entry_reinit_vld      = 1'b0;
        entry_pf_inst_vld     = 1'b0;
        entry_inst_new_va     = '0;
        entry_stride          = '0;
        entry_stride_neg      = 1'b0;
        cp0_lsu_pfu_l1_dist   = 2'd0;
        entry_l1_mmu_ack_vld  = 1'b0;
        entry_l1_mmu_ack_err  = 1'b0;
        entry_l1_mmu_ack_ppn  = '0;
        entry_biu_pe_req_grnt = 1'b0;
        entry_biu_pe_req_src  = 2'b00;
        rnd_mode              = 1'b0;

        // Reset values.
        repeat (2) @(negedge entry_clk);
        chk("rst_mmu_set", 40'(entry_l1_mmu_pe_req_set), 40'd0);
        chk("rst_biu_set", 40'(entry_l1_biu_pe_req_set), 40'd0);
        chk("rst_pf_va", entry_l1_pf_va, 40'd0);
        chk("rst_pf_pa", entry_l1_pf_pa, 40'd0);
        chk("rst_cnt", 40'(entry_l1_cnt), 40'd0);
        cpurst_b = 1'b1;
        tick();
        chk("idle_mmu_set", 40'(entry_l1_mmu_pe_req_set), 40'd0);

        // Walk to the 4-line distance in one page.
        start(40'h00_1000_0000, 11'h040, 1'b0, 2'd1);
        ack(28'h123);
        chk("d1_pf_pa", entry_l1_pf_pa, 40'h00_0012_3000);
        guard = 0;
        while (m_exp != 0 && guard < 20) begin
            if (m_exp == 1) ack(28'h123);
            else grant(1'b0, 2'd1);
            guard++;
        end
        chk("d1_cnt", 40'(entry_l1_cnt), 40'd4);
        chk("d1_pf_va", entry_l1_pf_va, 40'h00_1000_0100);

        // One demand hit reopens one slot, then back to FULL.
        consume();
        chk("d2_cnt", 40'(entry_l1_cnt), 40'd3);
        guard = 0;
        while (m_exp != 0 && guard < 20) begin
            if (m_exp == 1) ack(28'h123);
            else grant(1'b0, 2'd1);
            guard++;
        end
        chk("d2_cnt_full", 40'(entry_l1_cnt), 40'd4);

        // Crossing into the next page forces a fresh translation.
        start(40'h00_1000_0FC0, 11'h040, 1'b0, 2'd1);
        ack(28'h055);
        grant(1'b0, 2'd1);
        chk("d3_pf_va", entry_l1_pf_va, 40'h00_1000_1000);
        chk("d3_mmu_set", 40'(entry_l1_mmu_pe_req_set), 40'd1);

        // Negative stride.
        start(40'h00_2000_0000, 11'h7C0, 1'b1, 2'd1);
        ack(28'h077);
        grant(1'b0, 2'd1);
        chk("d4_pf_va", entry_l1_pf_va, 40'h00_1FFF_FFC0);
        chk("d4_mmu_set", 40'(entry_l1_mmu_pe_req_set), 40'd1);

        // Translation error parks in STOP; reinit restarts from IDLE.
        start(40'h00_3000_0FC0, 11'h040, 1'b0, 2'd1);
        ack(28'h099);
        grant(1'b0, 2'd1);
        tick();
        check_state("d5_wait_ppn", 0);
        entry_l1_mmu_ack_vld = 1'b1;
        entry_l1_mmu_ack_err = 1'b1;
        tick();
        entry_l1_mmu_ack_vld = 1'b0;
        entry_l1_mmu_ack_err = 1'b0;
        check_state("d5_stop", 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("d5_stop_quiet",
                40'({entry_l1_mmu_pe_req_set, entry_l1_biu_pe_req_set}), 40'd0);
        end
        entry_reinit_vld = 1'b1;
        tick();
        entry_reinit_vld = 1'b0;
        chk("d5_reinit_cnt", 40'(entry_l1_cnt), 40'd0);
        chk("d5_reinit_mmu_set", 40'(entry_l1_mmu_pe_req_set), 40'd0);
        tick();
        chk("d5_restart_mmu_set", 40'(entry_l1_mmu_pe_req_set), 40'd1);
        chk("d5_restart_pf_va", entry_l1_pf_va, 40'h00_3000_0FC0);

        // Pop in the grant cycle wins over the grant.
        start(40'h00_4000_0000, 11'h040, 1'b0, 2'd1);
        ack(28'h011);
        tick();
        check_state("d6_wait_biu", 0);
        entry_biu_pe_req_grnt = 1'b1;
        entry_biu_pe_req_src  = 2'b01;
        entry_pop_vld         = 1'b1;
        entry_tsm_is_judge    = 1'b0;
        tick();
        entry_biu_pe_req_grnt = 1'b0;
        entry_biu_pe_req_src  = 2'b00;
        entry_pop_vld         = 1'b0;
        chk("d6_pop_cnt", 40'(entry_l1_cnt), 40'd0);
        for (int i = 0; i < 5; i++) begin
            chk("d6_pop_quiet",
                40'({entry_l1_mmu_pe_req_set, entry_l1_biu_pe_req_set}), 40'd0);
            tick();
        end

        // Randomized walks.
        rnd_mode = 1'b1;
        for (int t = 0; t < 25; t++) begin
            start(40'({$urandom, $urandom}), 11'($urandom_range(0, 2047)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            for (int k = 0; k < 30; k++) serve();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
